// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: IF-stage fetch-group address generator.
// Produces an aligned group of FETCH_W instruction addresses. Arbitrates
// exception and branch redirects, holds a redirect that arrives while fetch
// is stalled, and waits out the MIPS branch delay slot.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned targets are kept
// as-is and flagged on addr_err; otherwise bits [1:0] of targets are cleared).
module fetch_pc_gen #(
    parameter int unsigned FETCH_W  = 2,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go_if,
    input  logic                   exc_valid,
    input  logic [31:0]            exc_target,
    input  logic                   br_valid,
    input  logic [31:0]            br_target,
    input  logic                   br_need_ds,
    output logic [31:0]            pc,
    output logic [32*FETCH_W-1:0]  pc_group,
    output logic [FETCH_W-1:0]     pc_valid,
    output logic [31:0]            npc,
    output logic                   redirect_pending,
    output logic                   addr_err
);

    localparam logic [31:0] GB       = 32'(4 * FETCH_W);
    localparam logic [31:0] OFF_MASK = GB - 32'd1;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        DSWAIT
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_nx;
    logic [31:0] pend_target, pend_target_nx;
    logic        pend_exc, pend_exc_nx;
    logic [31:0] pc_word;
    logic [31:0] base;
    logic [31:0] lane_off;

    // Address actually written into pc for a redirect target.
    function automatic logic [31:0] load_addr(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    assign pc_word          = pc & 32'hFFFF_FFFC;
    assign base             = pc_word & ~OFF_MASK;
    assign lane_off         = (pc & OFF_MASK) >> 2;
    assign npc              = base + GB;
    assign redirect_pending = (state != RUN);

    // Expand the group base into per-lane addresses and lane-valid flags.
    always_comb begin
        pc_group = '0;
        pc_valid = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            pc_group[32*i +: 32] = base + 32'(4 * i);
            pc_valid[i]          = (32'(i) >= lane_off);
        end
    end

    // Redirect arbitration and next-PC selection.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        pend_target_nx = pend_target;
        pend_exc_nx    = pend_exc;
        if (exc_valid) begin
            // An exception overrides and discards any held branch.
            if (go_if) begin
                pc_nx       = load_addr(exc_target);
                state_nx    = RUN;
                pend_exc_nx = 1'b0;
            end else begin
                pend_target_nx = exc_target;
                pend_exc_nx    = 1'b1;
                state_nx       = HOLD;
            end
        end else begin
            case (state)
                RUN: begin
                    if (br_valid) begin
                        if (br_need_ds) begin
                            // Target waits; a same-cycle advance fetches the delay slot.
                            pend_target_nx = br_target;
                            state_nx       = DSWAIT;
                            if (go_if) pc_nx = npc;
                        end else if (go_if) begin
                            pc_nx = load_addr(br_target);
                        end else begin
                            pend_target_nx = br_target;
                            state_nx       = HOLD;
                        end
                    end else if (go_if) begin
                        pc_nx = npc;
                    end
                end
                HOLD, DSWAIT: begin
                    if (go_if) begin
                        pc_nx       = load_addr(pend_target);
                        state_nx    = RUN;
                        pend_exc_nx = 1'b0;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // State, pc and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            pend_target <= '0;
            pend_exc    <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pend_target <= pend_target_nx;
            pend_exc    <= pend_exc_nx;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic addr_err_q;

    // Misalignment flag registered together with pc.
    always_ff @(posedge clk) begin
        if (rst) addr_err_q <= 1'b0;
        else     addr_err_q <= |pc_nx[1:0];
    end

    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vector table, a wrap-around sequence, and a
// randomized run compared against a queue-based reference model.
module tb_fetch_pc_gen;

    localparam int          FW  = 2;
    localparam int          GB  = 4 * FW;
    localparam logic [31:0] RPC = 32'hBFC0_0000;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_PC  = 32'h0000_1002;
    localparam logic        MIS_ERR = 1'b1;
`else
    localparam logic [31:0] MIS_PC  = 32'h0000_1000;
    localparam logic        MIS_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, go_if, exc_valid, br_valid, br_need_ds;
    logic [31:0]       exc_target, br_target;
    logic [31:0]       pc, npc;
    logic [32*FW-1:0]  pc_group;
    logic [FW-1:0]     pc_valid;
    logic              redirect_pending, addr_err;

    int checks = 0;
    int errors = 0;

    fetch_pc_gen #(.FETCH_W(FW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .go_if(go_if),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .br_valid(br_valid), .br_target(br_target), .br_need_ds(br_need_ds),
        .pc(pc), .pc_group(pc_group), .pc_valid(pc_valid), .npc(npc),
        .redirect_pending(redirect_pending), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, go, exc;
        logic [31:0] exct;
        logic        br;
        logic [31:0] brt;
        logic        ds;
        logic [31:0] epc;
        logic        epend, eerr;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against what the specification derives from an expected pc.
    task automatic check_all(input string tag, input logic [31:0] epc, input logic epend, input logic eerr);
        logic [31:0]      b, en;
        logic [32*FW-1:0] eg;
        logic [FW-1:0]    ev;
        int unsigned      off;
        b   = (epc & ~32'd3) & ~(32'(GB) - 32'd1);
        en  = b + 32'(GB);
        off = int'((epc % 32'(GB)) / 4);
        for (int i = 0; i < FW; i++) begin
            eg[32*i +: 32] = b + 32'(4 * i);
            ev[i]          = (i >= off);
        end
        chk({tag, ".pc"},      128'(pc),               128'(epc));
        chk({tag, ".npc"},     128'(npc),              128'(en));
        chk({tag, ".group"},   128'(pc_group),         128'(eg));
        chk({tag, ".valid"},   128'(pc_valid),         128'(ev));
        chk({tag, ".pending"}, 128'(redirect_pending), 128'(epend));
        chk({tag, ".adderr"},  128'(addr_err),         128'(eerr));
    endtask

    task automatic drive(input logic r, input logic g, input logic e, input logic [31:0] et,
                         input logic b, input logic [31:0] bt, input logic d);
        rst = r; go_if = g; exc_valid = e; exc_target = et;
        br_valid = b; br_target = bt; br_need_ds = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: pc plus a queue holding at most one outstanding redirect target.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];

    function automatic logic [31:0] ld(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    function automatic logic [31:0] seq_next(input logic [31:0] p);
        logic [31:0] w;
        w = p - (p % 4);
        return w - (w % 32'(GB)) + 32'(GB);
    endfunction

    function automatic logic m_err(input logic [31:0] p);
`ifdef PC_ALIGN_CHECK_EN
        return (p % 4) != 0;
`else
        return (p % 4) != 0;
`endif
    endfunction

    initial begin
        tbl[0]  = '{1,0,0,32'h0,0,32'h0,0,            32'hBFC0_0000,0,0};
        tbl[1]  = '{0,1,0,32'h0,0,32'h0,0,            32'hBFC0_0008,0,0};
        tbl[2]  = '{0,1,0,32'h0,0,32'h0,0,            32'hBFC0_0010,0,0};
        tbl[3]  = '{0,1,0,32'h0,1,32'h8000_0004,0,    32'h8000_0004,0,0};
        tbl[4]  = '{0,0,0,32'h0,1,32'h9000_0000,0,    32'h8000_0004,1,0};
        tbl[5]  = '{0,0,0,32'h0,0,32'h0,0,            32'h8000_0004,1,0};
        tbl[6]  = '{0,0,0,32'h0,0,32'h0,0,            32'h8000_0004,1,0};
        tbl[7]  = '{0,0,0,32'h0,0,32'h0,0,            32'h8000_0004,1,0};
        tbl[8]  = '{0,1,0,32'h0,0,32'h0,0,            32'h9000_0000,0,0};
        tbl[9]  = '{0,1,0,32'h0,1,32'h0000_0100,0,    32'h0000_0100,0,0};
        tbl[10] = '{0,1,0,32'h0,1,32'h0000_2000,1,    32'h0000_0108,1,0};
        tbl[11] = '{0,1,0,32'h0,0,32'h0,0,            32'h0000_2000,0,0};
        tbl[12] = '{0,1,1,32'h8000_0180,1,32'h4000,0, 32'h8000_0180,0,0};
        tbl[13] = '{0,1,0,32'h0,0,32'h0,0,            32'h8000_0188,0,0};
        tbl[14] = '{0,1,0,32'h0,1,32'h0000_5000,1,    32'h8000_0190,1,0};
        tbl[15] = '{0,0,1,32'hBFC0_0380,0,32'h0,0,    32'h8000_0190,1,0};
        tbl[16] = '{0,1,0,32'h0,0,32'h0,0,            32'hBFC0_0380,0,0};
        tbl[17] = '{0,1,0,32'h0,0,32'h0,0,            32'hBFC0_0388,0,0};
        tbl[18] = '{0,1,0,32'h0,1,32'h0000_1002,0,    MIS_PC,0,MIS_ERR};
        tbl[19] = '{0,1,0,32'h0,0,32'h0,0,            32'h0000_1008,0,0};
        tbl[20] = '{0,0,0,32'h0,1,32'h0000_7000,0,    32'h0000_1008,1,0};
        tbl[21] = '{0,1,0,32'h0,1,32'h0000_6000,0,    32'h0000_7000,0,0};
        tbl[22] = '{0,0,0,32'h0,1,32'h0000_3000,1,    32'h0000_7000,1,0};
        tbl[23] = '{1,0,0,32'h0,0,32'h0,0,            32'hBFC0_0000,0,0};
        tbl[24] = '{0,1,0,32'h0,0,32'h0,0,            32'hBFC0_0008,0,0};
        tbl[25] = '{1,1,1,32'h1234_0000,1,32'h0567_8000,0, 32'hBFC0_0000,0,0};

        rst = 1'b1; go_if = 1'b0; exc_valid = 1'b0; exc_target = '0;
        br_valid = 1'b0; br_target = '0; br_need_ds = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].go, tbl[i].exc, tbl[i].exct,
                  tbl[i].br, tbl[i].brt, tbl[i].ds);
            check_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].epend, tbl[i].eerr);
        end

        // Sequential fetch across the top of the address space wraps to zero.
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
        drive(0, 1, 0, 32'h0, 1, 32'hFFFF_FFF8, 0);
        check_all("wrap0", 32'hFFFF_FFF8, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
        check_all("wrap1", 32'h0000_0000, 0, 0);

        // Randomized traffic against the reference model.
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
        m_pc = RPC;
        m_q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic        r, g, e, b, d;
            logic [31:0] et, bt;
            r  = ($urandom_range(0, 99) < 1);
            g  = ($urandom_range(0, 99) < 70);
            e  = ($urandom_range(0, 99) < 5);
            b  = ($urandom_range(0, 99) < 15);
            d  = $urandom_range(0, 1) == 1;
            et = $urandom;
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
            if (r) begin
                m_pc = RPC;
                m_q.delete();
            end else if (e) begin
                m_q.delete();
                if (g) m_pc = ld(et);
                else   m_q.push_back(et);
            end else if (m_q.size() != 0) begin
                if (g) m_pc = ld(m_q.pop_front());
            end else if (b) begin
                if (d) begin
                    m_q.push_back(bt);
                    if (g) m_pc = seq_next(m_pc);
                end else if (g) begin
                    m_pc = ld(bt);
                end else begin
                    m_q.push_back(bt);
                end
            end else if (g) begin
                m_pc = seq_next(m_pc);
            end
            drive(r, g, e, et, b, bt, d);
            check_all("rnd", m_pc, m_q.size() != 0, m_err(m_pc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
